class_search_controller: RTL and testbench
==========================================

Name: class_search_controller

Overview:
Sequences the associative-search (inference) phase after encoding completes. Walks the class hypervector memory and the encoded query buffer chunk by chunk. Computes binary Hamming similarity (popcount of XNOR) per chunk, accumulates it per class, and tracks the running argmax. Presents the predicted class through a valid/ready handshake to the output/host logic.

Parameters:
NUM_CLASSES, 26, number of stored class hypervectors
Dhv_SIZE, 4000, hypervector dimension; must be a multiple of CHUNK_WIDTH
CHUNK_WIDTH, 16, dimensions per memory word
CLA_ADDR_WIDTH, 13, class memory address width; must cover NUM_CLASSES*Dhv_SIZE/CHUNK_WIDTH words
QRY_ADDR_WIDTH, 8, query buffer address width; must cover Dhv_SIZE/CHUNK_WIDTH words
SCORE_WIDTH, 12, accumulator width; must hold Dhv_SIZE
CLASS_IDX_WIDTH, 5, width of class index
REJECT_THRESHOLD, 2200, minimum winning score (used only with the optional feature)

Ports:
clk  in  1  clock
reset_in  in  1  synchronous, active-low reset
start  in  1  single-cycle pulse: encoded query is complete in the query buffer
query_addr  out  QRY_ADDR_WIDTH  query buffer word address
query_data  in  CHUNK_WIDTH  query word; sync RAM, valid 1 cycle after query_addr
class_addr  out  CLA_ADDR_WIDTH  class memory word address
class_data  in  CHUNK_WIDTH  class word; sync RAM, valid 1 cycle after class_addr
busy  out  1  high from start acceptance until result handshake completes
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
result_class  out  CLASS_IDX_WIDTH  index of best-matching class
result_score  out  SCORE_WIDTH  winning similarity score
result_reject  out  1  only with CLASS_SEARCH_REJECT_EN

Behaviour:
- W = Dhv_SIZE/CHUNK_WIDTH (250 by default). class_addr = c*W + w. Generate the base by incremental add of W; no multiplier.
- Reset (reset_in==0 at posedge): state IDLE. All outputs 0. Accumulator, best score and best index cleared. Reset mid-scan aborts immediately; no result is produced.
- States: IDLE, SCAN, DRAIN, HOLD.
- IDLE: addresses driven to 0. On start==1, go to SCAN and set busy=1.
- SCAN: each cycle issues (c, w), beginning at (0, 0). w wraps W-1→0 with c+1. After issuing (NUM_CLASSES-1, W-1), go to DRAIN.
- Pipeline stage 1 (data valid, one cycle after issue): chunk score = popcount(~(query_data ^ class_data)). If w==0, the accumulator loads the chunk score; otherwise it adds it. Carry a registered valid/w/c tag alongside the data.
- When the tagged w==W-1, the final class sum is compared against best. Replace best only if strictly greater, so ties keep the lowest index. Class 0 always loads best.
- DRAIN: one cycle for the last compare, then go to HOLD with result_valid=1.
- Latency: result_valid rises NUM_CLASSES*W+2 cycles after the edge that samples start.
- HOLD: result_class and result_score stay stable while result_valid=1. A transfer occurs on result_valid&&result_ready. On that cycle, clear result_valid and busy next cycle and go to IDLE. result_ready may be held high permanently.
- start while busy (SCAN/DRAIN/HOLD) is ignored, not queued.
- Accumulator cannot overflow given the parameter constraints. Widths are zero-extended.

Optional Feature:
CLASS_SEARCH_REJECT_EN
- Defined: result_reject port exists. It is registered with result_valid: 1 iff the winning score < REJECT_THRESHOLD. It clears with result_valid.
- Undefined: the port and compare logic are absent; all other behaviour is identical.

Decomposition:
- Shared package hd_pkg: Dhv_SIZE, CHUNK_WIDTH, NUM_CLASSES, the derived W, and the state enum typedef cs_state_t.
- Sub-module xnor_popcount (CHUNK_WIDTH in, $clog2(CHUNK_WIDTH)+1 out, combinational) isolates the per-chunk scoring.

Test Plan (bench params NUM_CLASSES=4, Dhv_SIZE=64, CHUNK_WIDTH=16, W=4):
1. Query all-ones; class 2 all-ones, other classes all-zeros; pulse start → result_valid at cycle 18, result_class=2, result_score=64; addresses sequence 0..15 / 0..3 repeating.
2. Classes 1 and 3 both identical to the query → result_class=1 (tie keeps lowest index), score=64.
3. Class scores 10/40/40/63 via bit patterns; hold result_ready=0 for 5 cycles → outputs stable; then ready=1 → valid/busy drop the next cycle, state IDLE.
4. Second start pulse mid-SCAN → ignored; latency and result unchanged; start after handshake → new scan begins at address 0.
5. reset_in=0 during cycle 7 of SCAN → all outputs 0 next cycle; no result_valid; fresh start runs normally.
6. With CLASS_SEARCH_REJECT_EN and REJECT_THRESHOLD=50: best score 40 → result_reject=1; best score 64 → result_reject=0.

Source files
------------

// File: rtl/hd_pkg.sv
// Shared hyperdimensional-classifier constants and the search FSM state type.
// Values here are the default build; the search controller exposes them as
// overridable parameters.
package hd_pkg;

    localparam int NUM_CLASSES = 26;
    localparam int Dhv_SIZE    = 4000;
    localparam int CHUNK_WIDTH = 16;
    localparam int W           = Dhv_SIZE / CHUNK_WIDTH;

    typedef enum logic [1:0] {
        CS_IDLE  = 2'd0,
        CS_SCAN  = 2'd1,
        CS_DRAIN = 2'd2,
        CS_HOLD  = 2'd3
    } cs_state_t;

endpackage

// File: rtl/class_search_controller_xnor_popcount.sv
// Per-chunk binary Hamming similarity: number of bit positions where the
// query word and the class word agree (popcount of XNOR). Purely combinational.
module xnor_popcount #(
    parameter int CHUNK_WIDTH = 16,
    parameter int CNT_W       = $clog2(CHUNK_WIDTH) + 1
) (
    input  logic [CHUNK_WIDTH-1:0] a_i,
    input  logic [CHUNK_WIDTH-1:0] b_i,
    output logic [CNT_W-1:0]       cnt_o
);

    logic [CHUNK_WIDTH-1:0] agree;

    // Count agreeing bit positions
    always_comb begin
        agree = ~(a_i ^ b_i);
        cnt_o = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            cnt_o = cnt_o + CNT_W'(agree[i]);
        end
    end

endmodule

// File: rtl/class_search_controller.sv
// Associative-search controller: walks every class hypervector against the
// encoded query chunk by chunk, accumulates Hamming similarity per class,
// keeps the running argmax and offers the winner on a valid/ready handshake.
// Optional feature macro: CLASS_SEARCH_REJECT_EN (adds result_reject).
module class_search_controller #(
    parameter int NUM_CLASSES     = hd_pkg::NUM_CLASSES,
    parameter int Dhv_SIZE        = hd_pkg::Dhv_SIZE,
    parameter int CHUNK_WIDTH     = hd_pkg::CHUNK_WIDTH,
    parameter int CLA_ADDR_WIDTH  = 13,
    parameter int QRY_ADDR_WIDTH  = 8,
    parameter int SCORE_WIDTH     = 12,
    parameter int CLASS_IDX_WIDTH = 5
`ifdef CLASS_SEARCH_REJECT_EN
    , parameter int REJECT_THRESHOLD = 2200
`endif
) (
    input  logic                       clk,
    input  logic                       reset_in,
    input  logic                       start,
    output logic [QRY_ADDR_WIDTH-1:0]  query_addr,
    input  logic [CHUNK_WIDTH-1:0]     query_data,
    output logic [CLA_ADDR_WIDTH-1:0]  class_addr,
    input  logic [CHUNK_WIDTH-1:0]     class_data,
    output logic                       busy,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [CLASS_IDX_WIDTH-1:0] result_class,
    output logic [SCORE_WIDTH-1:0]     result_score
`ifdef CLASS_SEARCH_REJECT_EN
    , output logic                     result_reject
`endif
);

    import hd_pkg::*;

    localparam int WORDS = Dhv_SIZE / CHUNK_WIDTH;
    localparam int CNT_W = $clog2(CHUNK_WIDTH) + 1;

    localparam logic [QRY_ADDR_WIDTH-1:0]  W_LAST = QRY_ADDR_WIDTH'(WORDS - 1);
    localparam logic [CLASS_IDX_WIDTH-1:0] C_LAST = CLASS_IDX_WIDTH'(NUM_CLASSES - 1);
    localparam logic [CLA_ADDR_WIDTH-1:0]  W_STEP = CLA_ADDR_WIDTH'(WORDS);

    cs_state_t                  state_q, state_d;
    logic [QRY_ADDR_WIDTH-1:0]  w_q, w_d;
    logic [CLASS_IDX_WIDTH-1:0] c_q, c_d;
    logic [CLA_ADDR_WIDTH-1:0]  base_q, base_d;

    logic                       vld_p0, vld_p1;
    logic [QRY_ADDR_WIDTH-1:0]  w_p0, w_p1;
    logic [CLASS_IDX_WIDTH-1:0] c_p0, c_p1;

    logic [CNT_W-1:0]           chunk_cnt;
    logic [SCORE_WIDTH-1:0]     acc_q;
    logic [SCORE_WIDTH-1:0]     best_q;
    logic [CLASS_IDX_WIDTH-1:0] best_idx_q;

    logic class_done;
    logic last_done;
    logic take_new;

    // Next-state logic: FSM plus (class, word) issue counters; class base
    // advances by WORDS on each class wrap so no multiplier is needed
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        c_d     = c_q;
        base_d  = base_q;
        case (state_q)
            CS_IDLE: begin
                if (start) state_d = CS_SCAN;
            end
            CS_SCAN: begin
                if (w_q == W_LAST) begin
                    w_d = '0;
                    if (c_q == C_LAST) begin
                        c_d     = '0;
                        base_d  = '0;
                        state_d = CS_DRAIN;
                    end else begin
                        c_d    = c_q + CLASS_IDX_WIDTH'(1);
                        base_d = base_q + W_STEP;
                    end
                end else begin
                    w_d = w_q + QRY_ADDR_WIDTH'(1);
                end
            end
            CS_DRAIN: begin
                if (last_done) state_d = CS_HOLD;
            end
            CS_HOLD: begin
                if (result_ready) state_d = CS_IDLE;
            end
            default: state_d = CS_IDLE;
        endcase
    end

    // Control registers: FSM, issue counters and pipeline valids
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            state_q <= CS_IDLE;
            w_q     <= '0;
            c_q     <= '0;
            base_q  <= '0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            c_q     <= c_d;
            base_q  <= base_d;
            vld_p0  <= (state_q == CS_SCAN);
            vld_p1  <= vld_p0;
        end
    end

    // Issue tags ride alongside the RAM read latency; qualified by vld_pN
    always_ff @(posedge clk) begin
        w_p0 <= w_q;
        c_p0 <= c_q;
        w_p1 <= w_p0;
        c_p1 <= c_p0;
    end

    // ---- stage p0 -> p1: RAM data valid, score chunk and accumulate ----
    xnor_popcount #(
        .CHUNK_WIDTH (CHUNK_WIDTH),
        .CNT_W       (CNT_W)
    ) u_xnor_popcount (
        .a_i   (query_data),
        .b_i   (class_data),
        .cnt_o (chunk_cnt)
    );

    // Accumulator restarts on the first word of each class
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            acc_q <= '0;
        end else if (vld_p0) begin
            if (w_p0 == '0) acc_q <= SCORE_WIDTH'(chunk_cnt);
            else            acc_q <= acc_q + SCORE_WIDTH'(chunk_cnt);
        end
    end

    // ---- stage p1 -> p2: completed class sum against running best ----
    assign class_done = vld_p1 && (w_p1 == W_LAST);
    assign last_done  = class_done && (c_p1 == C_LAST);
    // Strictly greater keeps the lowest index on ties; class 0 seeds best
    assign take_new   = (c_p1 == '0) || (acc_q > best_q);

    // Running argmax
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            best_q     <= '0;
            best_idx_q <= '0;
        end else if (class_done && take_new) begin
            best_q     <= acc_q;
            best_idx_q <= c_p1;
        end
    end

`ifdef CLASS_SEARCH_REJECT_EN
    logic [SCORE_WIDTH-1:0] best_next;
    logic                   reject_q;

    assign best_next = take_new ? acc_q : best_q;

    // Reject flag is registered together with the rise of result_valid
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            reject_q <= 1'b0;
        end else if (state_q == CS_DRAIN && last_done) begin
            reject_q <= (best_next < SCORE_WIDTH'(REJECT_THRESHOLD));
        end else if (state_q == CS_HOLD && result_ready) begin
            reject_q <= 1'b0;
        end
    end

    assign result_reject = reject_q;
`endif

    assign query_addr   = w_q;
    assign class_addr   = base_q + CLA_ADDR_WIDTH'(w_q);
    assign busy         = (state_q != CS_IDLE);
    assign result_valid = (state_q == CS_HOLD);
    assign result_class = best_idx_q;
    assign result_score = best_q;

endmodule

// File: tb/tb_class_search_controller.sv
// Bench for class_search_controller with 4 classes of 64 dimensions
// (4 words of 16 bits per class). Optional macro: CLASS_SEARCH_REJECT_EN.
module tb_class_search_controller;

    localparam int NC     = 4;
    localparam int DHV    = 64;
    localparam int CW     = 16;
    localparam int WW     = DHV / CW;
    localparam int NW     = NC * WW;
    localparam int THRESH = 50;

    logic        clk = 1'b0;
    logic        reset_in = 1'b0;
    logic        start = 1'b0;
    logic        result_ready = 1'b0;
    logic [7:0]  query_addr;
    logic [15:0] query_data;
    logic [12:0] class_addr;
    logic [15:0] class_data;
    logic        busy;
    logic        result_valid;
    logic [4:0]  result_class;
    logic [11:0] result_score;
`ifdef CLASS_SEARCH_REJECT_EN
    logic        result_reject;
`endif

    logic [15:0] qmem [WW];
    logic [15:0] cmem [NW];

    typedef struct packed {
        logic [15:0]     q;
        logic [3:0][7:0] sc;
        logic [7:0]      cls;
        logic [7:0]      score;
    } vec_t;

    typedef struct packed {
        logic [7:0]  cls;
        logic [11:0] score;
    } exp_t;

    exp_t sb [$];
    vec_t vecs [7];
    int checks = 0;
    int errors = 0;

    class_search_controller #(
        .NUM_CLASSES (NC),
        .Dhv_SIZE    (DHV),
        .CHUNK_WIDTH (CW)
`ifdef CLASS_SEARCH_REJECT_EN
        , .REJECT_THRESHOLD (THRESH)
`endif
    ) dut (
        .clk          (clk),
        .reset_in     (reset_in),
        .start        (start),
        .query_addr   (query_addr),
        .query_data   (query_data),
        .class_addr   (class_addr),
        .class_data   (class_data),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_class (result_class),
        .result_score (result_score)
`ifdef CLASS_SEARCH_REJECT_EN
        , .result_reject (result_reject)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read memories, one cycle latency
    always @(posedge clk) begin
        query_data <= (int'(query_addr) < WW) ? qmem[query_addr[1:0]] : 16'hDEAD;
        class_data <= (int'(class_addr) < NW) ? cmem[class_addr[3:0]] : 16'hBEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] q, input int s0, input int s1,
                                input int s2, input int s3, input int cls, input int score);
        vec_t v;
        v.q     = q;
        v.sc[0] = 8'(s0);
        v.sc[1] = 8'(s1);
        v.sc[2] = 8'(s2);
        v.sc[3] = 8'(s3);
        v.cls   = 8'(cls);
        v.score = 8'(score);
        return v;
    endfunction

    // Build class words so that class c agrees with the query in exactly sc[c] bits
    task automatic load(input vec_t v);
        for (int w = 0; w < WW; w++) qmem[w] = v.q;
        for (int c = 0; c < NC; c++) begin
            int d;
            d = DHV - int'(v.sc[c]);
            for (int w = 0; w < WW; w++) begin
                int n;
                logic [15:0] m;
                n = (d > CW) ? CW : d;
                m = (n >= CW) ? 16'hFFFF : 16'((32'd1 << n) - 32'd1);
                cmem[c * WW + w] = v.q ^ m;
                d = d - n;
            end
        end
    endtask

    task automatic run(input vec_t v, input bit chk_addr, input int restart_at, input int hold);
        exp_t e;
        int   cyc;
        load(v);
        e.cls   = v.cls;
        e.score = 12'(v.score);
        sb.push_back(e);
        result_ready = (hold == 0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        chk("busy_after_start", 32'(busy), 32'd1);
        while (!result_valid && cyc < 100) begin
            if (chk_addr && cyc < NW) begin
                chk("class_addr", 32'(class_addr), 32'(cyc));
                chk("query_addr", 32'(query_addr), 32'(cyc % WW));
            end
            if (restart_at > 0 && cyc == restart_at) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(NW + 2));
        e = sb.pop_front();
        chk("result_class", 32'(result_class), 32'(e.cls));
        chk("result_score", 32'(result_score), 32'(e.score));
`ifdef CLASS_SEARCH_REJECT_EN
        chk("result_reject", 32'(result_reject), 32'(int'(e.score) < THRESH));
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(result_valid), 32'd1);
            chk("hold_class", 32'(result_class), 32'(e.cls));
            chk("hold_score", 32'(result_score), 32'(e.score));
        end
        result_ready = 1'b1;
        @(negedge clk);
        chk("valid_drop", 32'(result_valid), 32'd0);
        chk("busy_drop", 32'(busy), 32'd0);
`ifdef CLASS_SEARCH_REJECT_EN
        chk("reject_drop", 32'(result_reject), 32'd0);
`endif
    endtask

    initial begin
        int seen;
        vecs[0] = mk(16'hFFFF,  0,  0, 64,  0, 2, 64);
        vecs[1] = mk(16'hA5C3, 20, 64, 30, 64, 1, 64);
        vecs[2] = mk(16'h0F0F, 10, 40, 40, 63, 3, 63);
        vecs[3] = mk(16'h1234, 10, 40, 40,  5, 1, 40);
        vecs[4] = mk(16'h0000, 32, 32, 32, 32, 0, 32);
        vecs[5] = mk(16'hFFFF,  0,  0,  0,  0, 0,  0);
        vecs[6] = mk(16'h5A5A,  5, 17,  3, 16, 1, 17);
        load(vecs[0]);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_class", 32'(result_class), 32'd0);
        chk("rst_score", 32'(result_score), 32'd0);
        chk("rst_class_addr", 32'(class_addr), 32'd0);
        chk("rst_query_addr", 32'(query_addr), 32'd0);
        reset_in = 1'b1;
        @(negedge clk);

        // Table: v0 checks addresses, v1 gets an ignored start mid-scan and
        // rechecks addresses after the prior handshake, v2 holds ready low
        for (int i = 0; i < 7; i++) begin
            run(vecs[i], (i <= 1), (i == 1) ? 5 : 0, (i == 2) ? 5 : 0);
        end

        // Reset during SCAN aborts the search
        load(vecs[0]);
        result_ready = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (7) @(negedge clk);
        reset_in = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(result_valid), 32'd0);
        chk("abort_class", 32'(result_class), 32'd0);
        chk("abort_score", 32'(result_score), 32'd0);
        chk("abort_class_addr", 32'(class_addr), 32'd0);
        chk("abort_query_addr", 32'(query_addr), 32'd0);
        reset_in = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (result_valid || busy) seen++;
        end
        chk("no_result_after_abort", 32'(seen), 32'd0);

        // Fresh search after the abort
        run(vecs[6], 1'b1, 0, 0);
        run(vecs[0], 1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
